// File: rtl/cache_wb.sv
// Direct-mapped write-back / write-allocate cache with a word-serial memory port
// and a flush sequencer that writes every dirty line back without invalidating it.
module cache_wb #(
  parameter int IDX_W = 6,
  parameter int OFS_W = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        PStrobe,
  input  logic        PRw,
  input  logic [31:0] PAddress,
  input  logic [31:0] PData_out,
  output logic [31:0] PData_in,
  output logic        CReady,
  output logic        SysStrobe,
  output logic        SysRW,
  output logic [31:0] SysAddress,
  output logic [31:0] SysData_in,
  input  logic [31:0] SysData_out,
  input  logic        SysReady,
  input  logic        FlushReq,
  output logic        FlushDone
);
  localparam int TAG_W = 30 - IDX_W - OFS_W;
  localparam int LINES = 1 << IDX_W;
  localparam int WORDS = 1 << OFS_W;

  typedef enum logic [2:0] {IDLE, WRITEBACK, REFILL, RESPOND, FLUSH_SCAN, FLUSH_WB} state_t;

  state_t            state;
  logic [31:0]       req_addr;
  logic              req_rw;
  logic [31:0]       req_data;
  logic [OFS_W-1:0]  wcnt;
  logic [IDX_W-1:0]  fidx;
  logic [LINES-1:0]  valid, dirty;
  logic              flush_done;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES*WORDS];

  logic [TAG_W-1:0]  p_tag, r_tag;
  logic [IDX_W-1:0]  p_idx, r_idx, cidx;
  logic [OFS_W-1:0]  r_ofs;
  logic              p_hit, last_word, wb_state;

  assign p_tag     = PAddress[31 -: TAG_W];
  assign p_idx     = PAddress[IDX_W+OFS_W+1 : OFS_W+2];
  assign r_tag     = req_addr[31 -: TAG_W];
  assign r_idx     = req_addr[IDX_W+OFS_W+1 : OFS_W+2];
  assign r_ofs     = req_addr[OFS_W+1 : 2];
  assign p_hit     = valid[p_idx] && (tag_mem[p_idx] == p_tag);
  assign last_word = (wcnt == OFS_W'(WORDS-1));
  assign wb_state  = (state == WRITEBACK) || (state == FLUSH_WB);
  // Flush walks its own index; everything else works on the captured request.
  assign cidx      = (state == FLUSH_SCAN || state == FLUSH_WB) ? fidx : r_idx;

  assign CReady     = (state == RESPOND);
  assign PData_in   = data_mem[{r_idx, r_ofs}];
  assign SysStrobe  = wb_state || (state == REFILL);
  assign SysRW      = !wb_state;
  assign SysData_in = wb_state ? data_mem[{cidx, wcnt}] : 32'd0;
  assign FlushDone  = flush_done;

  always_comb begin
    SysAddress = 32'd0;
    if (wb_state)              SysAddress = {tag_mem[cidx], cidx, wcnt, 2'b00};
    else if (state == REFILL)  SysAddress = {r_tag, r_idx, wcnt, 2'b00};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_addr   <= '0;
      req_rw     <= 1'b1;
      req_data   <= '0;
      wcnt       <= '0;
      fidx       <= '0;
      valid      <= '0;
      dirty      <= '0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (PStrobe) begin
            req_addr <= PAddress;
            req_rw   <= PRw;
            req_data <= PData_out;
            if (p_hit)                             state <= RESPOND;
            else if (valid[p_idx] && dirty[p_idx]) state <= WRITEBACK;
            else                                   state <= REFILL;
          end else if (FlushReq) begin
            fidx  <= '0;
            state <= FLUSH_SCAN;
          end
        end
        WRITEBACK: if (SysReady) begin
          wcnt <= last_word ? '0 : wcnt + 1'b1;
          if (last_word) state <= REFILL;
        end
        REFILL: if (SysReady) begin
          wcnt <= last_word ? '0 : wcnt + 1'b1;
          if (last_word) begin
            valid[r_idx] <= 1'b1;
            dirty[r_idx] <= 1'b0;
            state        <= RESPOND;
          end
        end
        RESPOND: begin
          if (!req_rw) dirty[r_idx] <= 1'b1;
          state <= IDLE;
        end
        FLUSH_SCAN: begin
          if (valid[fidx] && dirty[fidx]) state <= FLUSH_WB;
          else if (fidx == IDX_W'(LINES-1)) begin
            fidx       <= '0;
            flush_done <= 1'b1;
            state      <= IDLE;
          end else fidx <= fidx + 1'b1;
        end
        FLUSH_WB: if (SysReady) begin
          wcnt <= last_word ? '0 : wcnt + 1'b1;
          if (last_word) begin
            dirty[fidx] <= 1'b0;
            if (fidx == IDX_W'(LINES-1)) begin
              fidx       <= '0;
              flush_done <= 1'b1;
              state      <= IDLE;
            end else begin
              fidx  <= fidx + 1'b1;
              state <= FLUSH_SCAN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clock) begin
    if (state == REFILL && SysReady) begin
      data_mem[{r_idx, wcnt}] <= SysData_out;
      if (last_word) tag_mem[r_idx] <= r_tag;
    end
    if (state == RESPOND && !req_rw) data_mem[{r_idx, r_ofs}] <= req_data;
  end
endmodule

// File: doc/cache_wb.md
CACHE_WB -- requirements
Module: cache_wb

Interface
REQ-001 The block SHALL have parameter IDX_W, default 6, meaning line-index width; the cache holds 2^IDX_W lines.
REQ-002 The block SHALL have parameter OFS_W, default 4, meaning word-offset width; each line holds 2^OFS_W 32-bit words.
REQ-003 The block SHALL derive TAG_W = 30-IDX_W-OFS_W; the address splits as tag [31:IDX_W+OFS_W+2], index [IDX_W+OFS_W+1:OFS_W+2], offset [OFS_W+1:2], byte [1:0] ignored.
REQ-004 The block SHALL have one clock, clock; reset is asynchronous and active-low, named reset.
REQ-005 Port list (name direction width meaning): clock in 1 clock; reset in 1 async active-low reset.
REQ-006 PStrobe in 1 processor request; PRw in 1 (1=read, 0=write); PAddress in 32 word address; PData_out in 32 processor write data.
REQ-007 PData_in out 32 read data to processor; CReady out 1 one-cycle completion pulse.
REQ-008 SysStrobe out 1 memory request; SysRW out 1 (1=read, 0=write); SysAddress out 32; SysData_in out 32 write data to memory; SysData_out in 32 read data from memory; SysReady in 1 per-word acknowledge.
REQ-009 FlushReq in 1 level request to write back all dirty lines; FlushDone out 1 one-cycle pulse.

Function
REQ-010 The cache SHALL be direct-mapped, write-back and write-allocate, with per-line valid bit, dirty bit and tag.
REQ-011 States SHALL be IDLE, WRITEBACK, REFILL, RESPOND, FLUSH_SCAN, FLUSH_WB.
REQ-012 In IDLE with PStrobe=1, the block SHALL capture PAddress, PRw and PData_out on the clock edge; later changes are ignored until CReady.
REQ-013 Hit (valid and tag equal) SHALL go to RESPOND; CReady=1 for exactly one cycle, the cycle after capture.
REQ-014 On a read hit, PData_in SHALL carry the addressed word while CReady=1.
REQ-015 On a write hit, the word SHALL be written and dirty set, at the edge ending RESPOND.
REQ-016 Miss with victim valid and dirty SHALL enter WRITEBACK; otherwise it SHALL enter REFILL.
REQ-017 WRITEBACK: SysStrobe=1, SysRW=0, SysAddress={victim tag, index, word counter, 2'b00}, SysData_in=stored word; the counter advances on each SysReady; after word 2^OFS_W-1 the block enters REFILL.
REQ-018 REFILL: SysStrobe=1, SysRW=1, SysAddress={request tag, index, counter, 2'b00}; SysData_out is written to the counter word on each SysReady.
REQ-019 After the last refill word, tag is updated, valid=1, dirty=0, then RESPOND completes the captured request per REQ-014/015.
REQ-020 SysStrobe, SysRW, SysAddress and SysData_in SHALL remain stable while SysReady=0; there is no timeout.
REQ-021 In IDLE with FlushReq=1 and PStrobe=0, the block SHALL enter FLUSH_SCAN at index 0.
REQ-022 FLUSH_SCAN SHALL test one index per cycle; a dirty line goes to FLUSH_WB (REQ-017 sequence), then clears dirty only, keeps valid, and resumes at the next index.
REQ-023 After the last index, FlushDone SHALL pulse one cycle and the block returns to IDLE.
REQ-024 PStrobe SHALL take priority over FlushReq in IDLE; requests outside IDLE are not accepted.
REQ-025 Word and index counters SHALL wrap to 0 when each sequence ends.

Reset
REQ-026 When reset=0, state=IDLE, all valid and dirty bits=0, counters=0, CReady=0, SysStrobe=0, SysRW=1, FlushDone=0, immediately and asynchronously.
REQ-027 Reset mid-sequence SHALL abort it with no further Sys traffic; partial lines are invalid, and dirty data is discarded.
REQ-028 Tag and data arrays are not reset.

Verification (IDX_W=2, OFS_W=2)
REQ-029 Read miss 0x40 after reset -> 4 reads at 0x40..0x4C returning A0..A3; CReady with PData_in=A0; read 0x44 -> CReady next cycle, data A1, SysStrobe stays 0.
REQ-030 Write 0x48 data 0x1234 on hit -> CReady next cycle, no Sys traffic; read 0x48 returns 0x1234.
REQ-031 Then read 0x80 -> writes to 0x40..0x4C data A0,A1,0x1234,A3, then reads 0x80..0x8C, then CReady.
REQ-032 Dirty lines at index 0 and 2, FlushReq -> writebacks index 0 then 2 only, one FlushDone pulse; repeat flush -> no Sys traffic, FlushDone 5 cycles after acceptance.
REQ-033 SysReady held 0 for 10 cycles during refill -> SysStrobe and SysAddress constant, no CReady.
REQ-034 Reset after 2 refill words -> outputs at reset values at once; re-read 0x40 misses and refills 4 words.
